// File: rtl/mem_bus_arbiter_pkg.sv
// Shared definitions for the ROM/RAM bus arbiter: bus widths, wait-timer width,
// FSM state encodings and the bus-owner tag.
package mem_bus_arbiter_pkg;

   localparam int ARB_AW     = 13;
   localparam int ARB_DW     = 8;
   localparam int ARB_WAIT_W = 3;

   typedef enum logic [1:0] {
      ARB_IDLE = 2'd0,
      ARB_CPU  = 2'd1,
      ARB_EXT  = 2'd2,
      ARB_DONE = 2'd3
   } arbState_t;

   typedef enum logic {
      OWNER_CPU = 1'b0,
      OWNER_EXT = 1'b1
   } busOwner_t;

   // True while the memory strobes are being driven for either requester.
   function automatic logic isAccessState(arbState_t s);
      return (s == ARB_CPU) || (s == ARB_EXT);
   endfunction

endpackage

// File: rtl/mem_bus_arbiter_wait_timer.sv
// Loadable down-counter that paces one memory access. It is loaded with the
// wait-state count at grant and reports done once it has reached zero, so an
// access stays on the bus for loadValue+1 cycles.
module arb_wait_timer #(
   parameter int WIDTH = 3
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [WIDTH-1:0] loadValue,
   output logic             done
);

   logic [WIDTH-1:0] count;

   // Load on grant, otherwise count down and park at zero until the next load.
   always_ff @(posedge clk) begin
      if (reset) begin
         count <= '0;
      end else if (load) begin
         count <= loadValue;
      end else if (count != '0) begin
         count <= count - WIDTH'(1);
      end
   end

   assign done = (count == '0);

endmodule

// File: rtl/mem_bus_arbiter.sv
// Arbiter for the shared ROM/RAM bus between the RISC core and the external
// loader/debug port. Each access is latched at grant, held on the bus for
// WAIT+1 cycles, followed by one turnaround cycle in which the winner is told
// it is finished (cpu_hold drops or ext_ack pulses).
module mem_bus_arbiter
   import mem_bus_arbiter_pkg::*;
#(
   parameter int AW        = ARB_AW,
   parameter int DW        = ARB_DW,
   parameter int WAIT      = 1,
   parameter int EXT_BURST = 4
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          cpu_rd,
   input  logic          cpu_wr,
   input  logic [AW-1:0] cpu_addr,
   input  logic [DW-1:0] cpu_wdata,
   input  logic          cpu_halt,
   output logic          cpu_hold,
   output logic [DW-1:0] cpu_rdata,
   input  logic          ext_req,
   input  logic          ext_we,
   input  logic [AW-1:0] ext_addr,
   input  logic [DW-1:0] ext_wdata,
   output logic          ext_ack,
   output logic [DW-1:0] ext_rdata,
   output logic          mem_rd,
   output logic          mem_wr,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata
);

   localparam int BCW = $clog2(EXT_BURST + 1);

   arbState_t      state;
   arbState_t      nextState;
   busOwner_t      owner;
   logic           cpuReq;
   logic           grantCpu;
   logic           grantExt;
   logic           burstFull;
   logic           timerDone;
   logic           accessLast;
   logic [BCW-1:0] burstCnt;

   assign cpuReq     = cpu_rd | cpu_wr;
   assign burstFull  = (burstCnt == BCW'(EXT_BURST));
   assign accessLast = isAccessState(state) && timerDone;

   arb_wait_timer #(
      .WIDTH(ARB_WAIT_W)
   ) waitTimer (
      .clk      (clk),
      .reset    (reset),
      .load     (grantCpu | grantExt),
      .loadValue(ARB_WAIT_W'(WAIT)),
      .done     (timerDone)
   );

   // State register; a reset mid-access simply drops back to IDLE.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= ARB_IDLE;
      end else begin
         state <= nextState;
      end
   end

   // Next-state and handshake logic. Ext normally wins a tie, except when it has
   // already taken EXT_BURST grants in a row over a waiting, non-halted core.
   // DONE always returns to IDLE so the winner's request is re-read afresh.
   always_comb begin
      nextState = state;
      grantCpu  = 1'b0;
      grantExt  = 1'b0;
      cpu_hold  = cpuReq;
      ext_ack   = 1'b0;
      case (state)
         ARB_IDLE: begin
            if (ext_req && !(cpuReq && burstFull && !cpu_halt)) begin
               grantExt  = 1'b1;
               nextState = ARB_EXT;
            end else if (cpuReq) begin
               grantCpu  = 1'b1;
               nextState = ARB_CPU;
            end
         end
         ARB_CPU, ARB_EXT: begin
            if (timerDone) begin
               nextState = ARB_DONE;
            end
         end
         ARB_DONE: begin
            nextState = ARB_IDLE;
            if (owner == OWNER_CPU) begin
               cpu_hold = 1'b0;
            end else begin
               ext_ack = 1'b1;
            end
         end
         default: nextState = ARB_IDLE;
      endcase
   end

   // Fairness counter: counts ext grants taken while the core waits, and is
   // cleared as soon as the core is served or stops asking.
   always_ff @(posedge clk) begin
      if (reset) begin
         burstCnt <= '0;
      end else if (!cpuReq || grantCpu) begin
         burstCnt <= '0;
      end else if (grantExt && !burstFull) begin
         burstCnt <= burstCnt + BCW'(1);
      end
   end

   // Request latch and bus drivers: the winner's command is captured at grant and
   // held unchanged until the last access cycle, where read data is captured
   // for the owner and the strobes are released for the turnaround cycle.
   // A simultaneous cpu_rd/cpu_wr is treated as a write.
   always_ff @(posedge clk) begin
      if (reset) begin
         owner     <= OWNER_CPU;
         mem_rd    <= 1'b0;
         mem_wr    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         cpu_rdata <= '0;
         ext_rdata <= '0;
      end else if (grantCpu) begin
         owner     <= OWNER_CPU;
         mem_rd    <= cpu_rd & ~cpu_wr;
         mem_wr    <= cpu_wr;
         mem_addr  <= cpu_addr;
         mem_wdata <= cpu_wdata;
      end else if (grantExt) begin
         owner     <= OWNER_EXT;
         mem_rd    <= ~ext_we;
         mem_wr    <= ext_we;
         mem_addr  <= ext_addr;
         mem_wdata <= ext_wdata;
      end else if (accessLast) begin
         mem_rd <= 1'b0;
         mem_wr <= 1'b0;
         if (mem_rd) begin
            if (owner == OWNER_CPU) begin
               cpu_rdata <= mem_rdata;
            end else begin
               ext_rdata <= mem_rdata;
            end
         end
      end
   end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: a WAIT=1 instance for the main
// scenarios and a WAIT=0 instance for back-to-back single-cycle accesses.
// Memory read data is modelled as the low address byte XOR 8'h99.
module tb_mem_bus_arbiter;

   typedef struct {
      logic [12:0] addr;
      logic        we;
      logic [7:0]  wdata;
   } access_t;

   typedef struct {
      logic       isRead;
      logic [7:0] data;
   } done_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        cpu_rd, cpu_wr, cpu_halt, ext_req, ext_we;
   logic [12:0] cpu_addr, ext_addr;
   logic [7:0]  cpu_wdata, ext_wdata;
   logic        cpu_hold, ext_ack, mem_rd, mem_wr;
   logic [7:0]  cpu_rdata, ext_rdata, mem_wdata, mem_rdata;
   logic [12:0] mem_addr;

   logic        fastCpuRd;
   logic [12:0] fastCpuAddr;
   logic        fastCpuHold, fastExtAck, fastMemRd, fastMemWr;
   logic [7:0]  fastCpuRdata, fastExtRdata, fastMemWdata, fastMemRdata;
   logic [12:0] fastMemAddr;

   int          total;
   int          bad;
   logic        monOn;
   logic        prevStrobe;

   access_t     accQ[$];
   done_t       cpuQ[$];
   done_t       extQ[$];
   logic [7:0]  fastQ[$];

   assign mem_rdata     = mem_addr[7:0] ^ 8'h99;
   assign fastMemRdata  = fastMemAddr[7:0] ^ 8'h99;

   always #5 clk = ~clk;

   mem_bus_arbiter #(.WAIT(1), .EXT_BURST(4)) dut (
      .clk(clk), .reset(reset),
      .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_halt(cpu_halt), .cpu_hold(cpu_hold), .cpu_rdata(cpu_rdata),
      .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
      .ext_ack(ext_ack), .ext_rdata(ext_rdata),
      .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata)
   );

   mem_bus_arbiter #(.WAIT(0), .EXT_BURST(4)) dutFast (
      .clk(clk), .reset(reset),
      .cpu_rd(fastCpuRd), .cpu_wr(1'b0), .cpu_addr(fastCpuAddr), .cpu_wdata(8'h00),
      .cpu_halt(1'b0), .cpu_hold(fastCpuHold), .cpu_rdata(fastCpuRdata),
      .ext_req(1'b0), .ext_we(1'b0), .ext_addr(13'h0000), .ext_wdata(8'h00),
      .ext_ack(fastExtAck), .ext_rdata(fastExtRdata),
      .mem_rd(fastMemRd), .mem_wr(fastMemWr), .mem_addr(fastMemAddr), .mem_wdata(fastMemWdata),
      .mem_rdata(fastMemRdata)
   );

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      total++;
      assert (observed === expected) else begin
         bad++;
         $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   task automatic nextCycle();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic rd, input logic wr, input logic [12:0] cAddr,
                                input logic [7:0] cData, input logic req, input logic we,
                                input logic [12:0] eAddr, input logic [7:0] eData, input logic halt);
      cpu_rd    = rd;
      cpu_wr    = wr;
      cpu_addr  = cAddr;
      cpu_wdata = cData;
      ext_req   = req;
      ext_we    = we;
      ext_addr  = eAddr;
      ext_wdata = eData;
      cpu_halt  = halt;
   endtask

   task automatic expectAccess(input logic [12:0] addr, input logic we, input logic [7:0] wdata);
      access_t a;
      a.addr  = addr;
      a.we    = we;
      a.wdata = wdata;
      accQ.push_back(a);
   endtask

   task automatic expectCpu(input logic isRead, input logic [7:0] data);
      done_t d;
      d.isRead = isRead;
      d.data   = data;
      cpuQ.push_back(d);
   endtask

   task automatic expectExt(input logic isRead, input logic [7:0] data);
      done_t d;
      d.isRead = isRead;
      d.data   = data;
      extQ.push_back(d);
   endtask

   task automatic checkCycle(input string tag, input logic hold, input logic rd, input logic wr, input logic ack);
      @(negedge clk);
      checkOutput({tag, "_hold"}, cpu_hold, hold);
      checkOutput({tag, "_rd"}, mem_rd, rd);
      checkOutput({tag, "_wr"}, mem_wr, wr);
      checkOutput({tag, "_ack"}, ext_ack, ack);
      nextCycle();
   endtask

   task automatic checkFastCycle(input string tag, input logic hold, input logic rd, input logic [12:0] addr);
      @(negedge clk);
      checkOutput({tag, "_hold"}, fastCpuHold, hold);
      checkOutput({tag, "_rd"}, fastMemRd, rd);
      checkOutput({tag, "_addr"}, fastMemAddr, addr);
      if (fastCpuRd && !fastCpuHold) begin
         checkOutput({tag, "_done_queued"}, fastQ.size() > 0, 1'b1);
         if (fastQ.size() > 0) begin
            checkOutput({tag, "_rdata"}, fastCpuRdata, fastQ.pop_front());
         end
      end
      nextCycle();
   endtask

   // Scoreboard monitor: pops the expected access on every strobe rising edge and
   // the expected completion whenever a requester is released.
   always @(negedge clk) begin
      access_t a;
      done_t   d;
      if (monOn) begin
         checkOutput("rd_wr_exclusive", mem_rd & mem_wr, 1'b0);
         checkOutput("fast_rd_wr_exclusive", fastMemRd & fastMemWr, 1'b0);
         if ((mem_rd | mem_wr) && !prevStrobe) begin
            checkOutput("acc_queued", accQ.size() > 0, 1'b1);
            if (accQ.size() > 0) begin
               a = accQ.pop_front();
               checkOutput("acc_addr", mem_addr, a.addr);
               checkOutput("acc_wr", mem_wr, a.we);
               checkOutput("acc_rd", mem_rd, !a.we);
               if (a.we) begin
                  checkOutput("acc_wdata", mem_wdata, a.wdata);
               end
            end
         end
         if ((cpu_rd | cpu_wr) && !cpu_hold) begin
            checkOutput("cpu_done_queued", cpuQ.size() > 0, 1'b1);
            checkOutput("cpu_done_strobes", mem_rd | mem_wr, 1'b0);
            if (cpuQ.size() > 0) begin
               d = cpuQ.pop_front();
               if (d.isRead) begin
                  checkOutput("cpu_rdata", cpu_rdata, d.data);
               end
            end
         end
         if (ext_ack) begin
            checkOutput("ext_done_queued", extQ.size() > 0, 1'b1);
            checkOutput("ext_done_strobes", mem_rd | mem_wr, 1'b0);
            if (extQ.size() > 0) begin
               d = extQ.pop_front();
               if (d.isRead) begin
                  checkOutput("ext_rdata", ext_rdata, d.data);
               end
            end
         end
         prevStrobe = mem_rd | mem_wr;
      end
   end

   // Directed scenarios, run in order.
   initial begin
      total       = 0;
      bad         = 0;
      monOn       = 1'b0;
      prevStrobe  = 1'b0;
      reset       = 1'b1;
      fastCpuRd   = 1'b0;
      fastCpuAddr = 13'h0000;
      applyStimulus(0, 0, 13'h0000, 8'h00, 0, 0, 13'h0000, 8'h00, 0);

      // Reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      checkOutput("rst_hold", cpu_hold, 1'b0);
      checkOutput("rst_ack", ext_ack, 1'b0);
      checkOutput("rst_mem_rd", mem_rd, 1'b0);
      checkOutput("rst_mem_wr", mem_wr, 1'b0);
      checkOutput("rst_mem_addr", mem_addr, 13'h0000);
      checkOutput("rst_mem_wdata", mem_wdata, 8'h00);
      checkOutput("rst_cpu_rdata", cpu_rdata, 8'h00);
      checkOutput("rst_ext_rdata", ext_rdata, 8'h00);
      checkOutput("rst_fast_rd", fastMemRd, 1'b0);
      nextCycle();
      reset = 1'b0;
      monOn = 1'b1;
      checkCycle("idle", 0, 0, 0, 0);

      // 1: CPU read 0A5, WAIT=1
      $display("[TB] scenario 1: cpu read");
      applyStimulus(1, 0, 13'h00A5, 8'h00, 0, 0, 13'h0000, 8'h00, 0);
      expectAccess(13'h00A5, 1'b0, 8'h00);
      expectCpu(1'b1, 8'h3C);
      checkCycle("t1c1", 1, 0, 0, 0);
      checkCycle("t1c2", 1, 1, 0, 0);
      checkCycle("t1c3", 1, 1, 0, 0);
      checkCycle("t1c4", 0, 0, 0, 0);
      cpu_rd = 1'b0;
      checkCycle("t1c5", 0, 0, 0, 0);

      // 2: ext write 1FFF/A5; later input changes must not reach the bus
      $display("[TB] scenario 2: ext write");
      applyStimulus(0, 0, 13'h0000, 8'h00, 1, 1, 13'h1FFF, 8'hA5, 0);
      expectAccess(13'h1FFF, 1'b1, 8'hA5);
      expectExt(1'b0, 8'h00);
      checkCycle("t2c1", 0, 0, 0, 0);
      ext_addr  = 13'h0000;
      ext_wdata = 8'h00;
      checkCycle("t2c2", 0, 0, 1, 0);
      @(negedge clk);
      checkOutput("t2_addr_held", mem_addr, 13'h1FFF);
      checkOutput("t2_wdata_held", mem_wdata, 8'hA5);
      checkOutput("t2c3_wr", mem_wr, 1'b1);
      nextCycle();
      checkCycle("t2c4", 0, 0, 0, 1);
      ext_req = 1'b0;
      checkCycle("t2c5", 0, 0, 0, 0);

      // 3: both requesting continuously -> E,E,E,E,C,E,E,E,E,C
      $display("[TB] scenario 3: burst fairness");
      applyStimulus(1, 0, 13'h0155, 8'h00, 1, 0, 13'h02AA, 8'h00, 0);
      for (int g = 0; g < 2; g++) begin
         for (int e = 0; e < 4; e++) begin
            expectAccess(13'h02AA, 1'b0, 8'h00);
            expectExt(1'b1, 8'h33);
         end
         expectAccess(13'h0155, 1'b0, 8'h00);
         expectCpu(1'b1, 8'hCC);
      end
      for (int i = 0; i < 120 && cpuQ.size() != 0; i++) begin
         nextCycle();
      end
      applyStimulus(0, 0, 13'h0000, 8'h00, 0, 0, 13'h0000, 8'h00, 0);
      checkOutput("t3_acc_left", accQ.size(), 0);
      checkOutput("t3_ext_left", extQ.size(), 0);
      checkOutput("t3_cpu_left", cpuQ.size(), 0);
      checkCycle("t3_idle", 0, 0, 0, 0);

      // 4: same with cpu_halt=1 -> ext only
      $display("[TB] scenario 4: halted core");
      applyStimulus(1, 0, 13'h0155, 8'h00, 1, 0, 13'h02AA, 8'h00, 1);
      for (int e = 0; e < 6; e++) begin
         expectAccess(13'h02AA, 1'b0, 8'h00);
         expectExt(1'b1, 8'h33);
      end
      for (int i = 0; i < 100 && extQ.size() != 0; i++) begin
         nextCycle();
      end
      checkOutput("t4_cpu_still_held", cpu_hold, 1'b1);
      applyStimulus(0, 0, 13'h0000, 8'h00, 0, 0, 13'h0000, 8'h00, 0);
      checkOutput("t4_acc_left", accQ.size(), 0);
      checkOutput("t4_ext_left", extQ.size(), 0);
      checkCycle("t4_idle", 0, 0, 0, 0);

      // 5: reset during the 2nd access cycle of an ext write, then re-grant
      $display("[TB] scenario 5: reset mid-access");
      applyStimulus(0, 0, 13'h0000, 8'h00, 1, 1, 13'h0333, 8'h5A, 0);
      expectAccess(13'h0333, 1'b1, 8'h5A);
      expectAccess(13'h0333, 1'b1, 8'h5A);
      expectExt(1'b0, 8'h00);
      checkCycle("t5c1", 0, 0, 0, 0);
      checkCycle("t5c2", 0, 0, 1, 0);
      reset = 1'b1;
      checkCycle("t5c3", 0, 0, 1, 0);
      reset = 1'b0;
      checkCycle("t5c4", 0, 0, 0, 0);
      checkCycle("t5c5", 0, 0, 1, 0);
      checkCycle("t5c6", 0, 0, 1, 0);
      checkCycle("t5c7", 0, 0, 0, 1);
      ext_req = 1'b0;
      checkCycle("t5c8", 0, 0, 0, 0);

      // 6: WAIT=0 back-to-back CPU reads 000, 001
      $display("[TB] scenario 6: zero wait states");
      fastCpuRd   = 1'b1;
      fastCpuAddr = 13'h0000;
      fastQ.push_back(8'h99);
      checkFastCycle("t6c1", 1, 0, 13'h0000);
      checkFastCycle("t6c2", 1, 1, 13'h0000);
      checkFastCycle("t6c3", 0, 0, 13'h0000);
      fastCpuAddr = 13'h0001;
      fastQ.push_back(8'h98);
      checkFastCycle("t6c4", 1, 0, 13'h0000);
      checkFastCycle("t6c5", 1, 1, 13'h0001);
      checkFastCycle("t6c6", 0, 0, 13'h0001);
      fastCpuRd = 1'b0;
      checkFastCycle("t6c7", 0, 0, 13'h0001);

      checkOutput("end_acc_left", accQ.size(), 0);
      checkOutput("end_cpu_left", cpuQ.size(), 0);
      checkOutput("end_ext_left", extQ.size(), 0);
      checkOutput("end_fast_left", fastQ.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
